// File: rtl/conf_int_add_pkg.sv
// rtl/conf_int_add_pkg.sv - shared types, constants and conf clamp for the conf_int_add sequencer
package conf_int_add_pkg;

  localparam int CONF_SELECT_W = 4;
  localparam int NUM_CONF      = 5;

  typedef logic [CONF_SELECT_W-1:0] conf_t;

  // Configuration 0 is full precision; anything unsupported falls back to it.
  localparam conf_t CONF_FULL = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECONF,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic conf_t clamp_conf(input conf_t c, input int unsigned num_conf);
    return (32'(c) < num_conf) ? c : CONF_FULL;
  endfunction

endpackage

// File: rtl/conf_int_add__settle_cnt.sv
// rtl/conf_int_add__settle_cnt.sv - loadable saturating down-counter with done flag
module conf_int_add__settle_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  // A load of N means done is seen on the N-th counting edge; zero never underflows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/conf_int_add__conf_ctrl.sv
// rtl/conf_int_add__conf_ctrl.sv - request/response sequencer in front of the noFF adder (option: CONF_INT_ADD_ERR_MON_EN)
module conf_int_add__conf_ctrl
  import conf_int_add_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int CONF_SELECT__C_B   = conf_int_add_pkg::CONF_SELECT_W,
  parameter int NUM_CONF           = conf_int_add_pkg::NUM_CONF,
  parameter int WAIT_CYC           = 1,
  parameter int SETTLE_CYC         = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] req_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] req_b,
  input  logic [CONF_SELECT__C_B-1:0]   req_conf,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] rsp_c,
  output logic [CONF_SELECT__C_B-1:0]   rsp_conf,
  output logic [DATA_PATH_BITWIDTH-1:0] rsp_err,
  output logic [DATA_PATH_BITWIDTH-1:0] add_a,
  output logic [DATA_PATH_BITWIDTH-1:0] add_b,
  output logic [CONF_SELECT__C_B-1:0]   add_conf_select,
  input  logic [DATA_PATH_BITWIDTH-1:0] add_c
);

  localparam int MAX_CYC = (WAIT_CYC > SETTLE_CYC) ? WAIT_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  state_e state_q, state_d;

  logic [DATA_PATH_BITWIDTH-1:0] add_a_q, add_b_q, rsp_c_q;
  logic [CONF_SELECT__C_B-1:0]   add_conf_q, rsp_conf_q, cur_conf_q, eff_conf;
  logic                          rsp_valid_q;

  logic          accept, capture, rsp_done;
  logic          cnt_load, cnt_en, cnt_done;
  logic [CW-1:0] cnt_val;

  assign eff_conf = CONF_SELECT__C_B'(clamp_conf(conf_t'(req_conf), NUM_CONF));
  assign accept   = req_valid && (state_q == ST_IDLE);

  conf_int_add__settle_cnt #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, counter control and capture strobes.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = CW'(WAIT_CYC);
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_load = 1'b1;
          if ((eff_conf != cur_conf_q) && (SETTLE_CYC > 0)) begin
            cnt_val = CW'(SETTLE_CYC);
            state_d = ST_RECONF;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_RECONF: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Adder-side operands only move on an accept so the adder never sees stray toggles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_conf_q <= '0;
    end else if (accept) begin
      add_a_q    <= req_a;
      add_b_q    <= req_b;
      add_conf_q <= eff_conf;
    end
  end

  // Response capture and handshake; the current conf tracks what the adder last settled on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_c_q     <= '0;
      rsp_conf_q  <= '0;
      cur_conf_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else if (capture) begin
      rsp_c_q     <= add_c;
      rsp_conf_q  <= add_conf_q;
      cur_conf_q  <= add_conf_q;
      rsp_valid_q <= 1'b1;
    end else if (rsp_done) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef CONF_INT_ADD_ERR_MON_EN
  logic [DATA_PATH_BITWIDTH-1:0] exact_q, rsp_err_q;

  // Exact reference sum, then its difference from the approximate result at capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exact_q   <= '0;
      rsp_err_q <= '0;
    end else begin
      if (accept)  exact_q   <= req_a + req_b;
      if (capture) rsp_err_q <= exact_q - add_c;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = '0;
`endif

  assign req_ready       = (state_q == ST_IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_c           = rsp_c_q;
  assign rsp_conf        = rsp_conf_q;
  assign add_a           = add_a_q;
  assign add_b           = add_b_q;
  assign add_conf_select = add_conf_q;

endmodule
